// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - debounced run/step controller producing a datapath step enable
//
// Purpose: turns three raw active-low push-buttons into a single-cycle datapath step
// enable. The buttons select between manual single-stepping and two automatic step
// rates. This replaces gated manual/slow/fast clocks with a clock enable.
//
// Ports:
//   iCLK_50     in   1   system clock, all state on rising edge
//   iRST        in   1   synchronous reset, active-high
//   iKEY        in   3   raw buttons, active-low: [0]=step, [1]=auto/manual, [2]=slow/fast
//   iHold       in   1   level, 1 freezes auto stepping and its divider
//   oStep       out  1   one-cycle datapath step enable
//   oMode       out  2   00=MANUAL, 01=AUTO_SLOW, 11=AUTO_FAST, 10=MANUAL with fast preselected
//   oStepCount  out  32  number of oStep pulses since reset (wraps)
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOW_DIV        = 10000000,
  parameter int FAST_DIV        = 31
) (
  input  logic        iCLK_50,
  input  logic        iRST,
  input  logic [2:0]  iKEY,
  input  logic        iHold,
  output logic        oStep,
  output logic [1:0]  oMode,
  output logic [31:0] oStepCount
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W   = $clog2(MAX_DIV);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    MANUAL      = 2'b00,
    AUTO_SLOW   = 2'b01,
    MANUAL_FAST = 2'b10,
    AUTO_FAST   = 2'b11
  } mode_e;

  // Key input path: synchronizer, debounce, press detect
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      deb_prev_q;
  logic [2:0]      armed_q, armed_d;
  logic [2:0]      press_q, press_d;
  logic [1:0]      valid_q;
  logic [DB_W-1:0] dbc_q [3];
  logic [DB_W-1:0] dbc_d [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      deb_d[k] = deb_q[k];
      dbc_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (dbc_q[k] == DB_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          dbc_d[k] = dbc_q[k] + DB_W'(1);
        end
      end
      // A key only becomes armed once a real (post-reset) synchronized sample agrees
      // with a released debounced value. A key held through reset is therefore
      // ignored until it has been seen released.
      armed_d[k] = armed_q[k] | (valid_q[1] & sync2_q[k] & deb_q[k]);
      press_d[k] = deb_prev_q[k] & ~deb_q[k] & armed_q[k];
    end
  end

  // Mode, divider and step generation
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_last;
  logic             step_q, step_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             toggle;

  always_comb begin
    mode_d   = mode_e'(mode_q ^ {press_q[2], press_q[1]});
    toggle   = press_q[2] | press_q[1];
    div_last = (mode_q == AUTO_FAST) ? FAST_LAST : SLOW_LAST;
    div_d    = div_q;
    step_d   = 1'b0;
    if (toggle) begin
      // A mode change restarts the divider and swallows any step due this cycle.
      div_d = '0;
    end else if (!mode_q[0]) begin
      div_d  = '0;
      step_d = press_q[0];
    end else if (!iHold) begin
      if (div_q == div_last) begin
        div_d  = '0;
        step_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
    step_d = step_d & ~step_q;
    cnt_d  = cnt_q + {31'd0, step_q};
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      armed_q    <= '0;
      press_q    <= '0;
      valid_q    <= '0;
      for (int k = 0; k < 3; k++) begin
        dbc_q[k] <= '0;
      end
      mode_q     <= MANUAL;
      div_q      <= '0;
      step_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= iKEY;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      armed_q    <= armed_d;
      press_q    <= press_d;
      valid_q    <= {valid_q[0], 1'b1};
      for (int k = 0; k < 3; k++) begin
        dbc_q[k] <= dbc_d[k];
      end
      mode_q     <= mode_d;
      div_q      <= div_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oStep      = step_q;
  assign oMode      = mode_q;
  assign oStepCount = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  key;
  logic        hold;
  logic        step;
  logic [1:0]  mode;
  logic [31:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int nsteps   = 0;
  int last_step = 0;
  int dbl      = 0;
  logic prev_step = 1'b0;

  int t0;
  int tm;
  int n0;
  logic [31:0] pat;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_DIV(10),
    .FAST_DIV(3)
  ) dut (
    .iCLK_50(clk),
    .iRST(rst),
    .iKEY(key),
    .iHold(hold),
    .oStep(step),
    .oMode(mode),
    .oStepCount(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step) begin
      nsteps++;
      last_step = cyc;
      if (prev_step) dbl++;
    end
    prev_step = step;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic capture(input int n, output logic [31:0] p);
    p = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      p[i] = step;
    end
  endtask

  task automatic wait_mode_change(input logic [1:0] from, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (mode != from) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(4);
  endtask

  initial begin
    rst  = 1'b1;
    key  = 3'b111;
    hold = 1'b0;
    run(2);
    rst = 1'b0;
    check("reset_step", 32'(step), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_count", count, 32'd0);
    run(4);

    // Manual single press held for 20 cycles
    n0 = nsteps;
    t0 = cyc;
    key[0] = 1'b0;
    run(20);
    check("manual_one_step", nsteps - n0, 32'd1);
    check("manual_latency", last_step - (t0 + 1), 32'd7);
    check("manual_count", count, 32'd1);
    check("manual_mode", 32'(mode), 32'd0);
    key[0] = 1'b1;
    run(10);
    check("release_no_step", nsteps - n0, 32'd1);

    // Short glitches are rejected
    do_reset();
    n0 = nsteps;
    for (int g = 0; g < 5; g++) begin
      key[0] = 1'b0;
      run(3);
      key[0] = 1'b1;
      run(5);
    end
    check("glitch_no_step", nsteps - n0, 32'd0);
    check("glitch_count", count, 32'd0);

    // A low of exactly DEBOUNCE_CYCLES samples is accepted
    n0 = nsteps;
    key[0] = 1'b0;
    run(4);
    key[0] = 1'b1;
    run(16);
    check("min_press_step", nsteps - n0, 32'd1);

    // KEY2 -> AUTO_SLOW
    t0 = cyc;
    key[1] = 1'b0;
    wait_mode_change(2'b00, 30);
    tm = cyc;
    check("auto_on_mode", 32'(mode), 32'd1);
    check("auto_on_latency", tm - t0, 32'd8);
    check("auto_on_no_step", 32'(step), 32'd0);
    key[1] = 1'b1;
    capture(32, pat);
    check("slow_period", pat, 32'h2008_0200);

    // KEY1 -> AUTO_FAST; toggle lands on a slow wrap, whose step must be swallowed
    t0 = cyc;
    key[2] = 1'b0;
    wait_mode_change(2'b01, 30);
    tm = cyc;
    check("fast_on_mode", 32'(mode), 32'd3);
    check("fast_on_latency", tm - t0, 32'd8);
    check("fast_on_no_step", 32'(step), 32'd0);
    key[2] = 1'b1;
    capture(12, pat);
    check("fast_period", pat, 32'h0000_0924);

    // Hold freezes the divider at 1, resume continues from it
    tick();
    hold = 1'b1;
    capture(20, pat);
    check("hold_no_step", pat, 32'd0);
    hold = 1'b0;
    capture(6, pat);
    check("hold_resume", pat, 32'h0000_0012);

    // KEY3 in AUTO adds nothing
    run(2);
    key[0] = 1'b0;
    capture(15, pat);
    check("auto_key3_held", pat, 32'h0000_4924);
    key[0] = 1'b1;
    capture(15, pat);
    check("auto_key3_released", pat, 32'h0000_4924);

    // Simultaneous KEY1 and KEY2 from MANUAL
    do_reset();
    key[2:1] = 2'b00;
    wait_mode_change(2'b00, 30);
    check("dual_toggle_mode", 32'(mode), 32'd3);
    key[2:1] = 2'b11;
    run(10);

    // Reset in AUTO_FAST with KEY3 held
    key[0] = 1'b0;
    run(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_count", count, 32'd0);
    check("midrst_step", 32'(step), 32'd0);
    capture(20, pat);
    check("held_after_reset", pat, 32'd0);
    key[0] = 1'b1;
    capture(10, pat);
    check("release_after_reset", pat, 32'd0);
    key[0] = 1'b0;
    capture(12, pat);
    check("repress_after_reset", pat, 32'h0000_0080);
    check("repress_count", count, 32'd1);
    key[0] = 1'b1;
    run(10);

    check("no_double_step", dbl, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
